// File: rtl/iteration_frame_writer.sv
// rtl/iteration_frame_writer.sv - burst requester, pixel FIFO and linear frame-buffer writer
//
// Purpose:
//   Consumer end of the rendering engine's pixel handshake. Requests bursts of
//   SET_SIZE iteration counts, buffers them in a pixel FIFO and writes one
//   8-bit pixel per accepted frame-buffer cycle at a linear address. At the
//   end of a frame the address wraps to 0, frame_done pulses and clear_frame
//   acknowledges the engine once it reports frame_ready.
//
// Optional feature macro: COLOR_MAP_EN
//   defined   : mem_wdata is RGB332, inside-set pixels are black
//   undefined : mem_wdata is the raw low byte of the iteration count
//
// Ports:
//   CLK          in   system clock
//   SYS_RESET_N  in   asynchronous active-low reset
//   render_reset in   synchronous flush, engine restarted
//   total_pixels in   pixels per frame, sampled while the address is 0
//   ready        in   engine has a burst available
//   data         in   engine burst word (HBI bits)
//   frame_ready  in   engine has emitted the whole frame
//   send_data    out  one-cycle burst request
//   clear_frame  out  one-cycle end-of-frame acknowledge
//   mem_we       out  frame-buffer write strobe
//   mem_addr     out  linear pixel address (20 bits)
//   mem_wdata    out  pixel value (8 bits)
//   mem_ready    in   frame buffer accepts the write this cycle
//   frame_done   out  one-cycle pulse after the last pixel is written
//   busy         out  high while a frame is being written

module iteration_frame_writer #(
  parameter int SET_SIZE   = 1,
  parameter int HBI        = 32,
  parameter int MAX_ITER   = 255,
  parameter int FIFO_DEPTH = 32
) (
  input  logic           CLK,
  input  logic           SYS_RESET_N,
  input  logic           render_reset,
  input  logic [20:0]    total_pixels,
  input  logic           ready,
  input  logic [HBI-1:0] data,
  input  logic           frame_ready,
  output logic           send_data,
  output logic           clear_frame,
  output logic           mem_we,
  output logic [19:0]    mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic           mem_ready,
  output logic           frame_done,
  output logic           busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CAPTURE,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    wcnt_q, wcnt_d;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    pix_mem [FIFO_DEPTH];

  logic          push, pop, fifo_full;
  logic          data_inside;
  logic [7:0]    head_pix;
  logic [7:0]    pix_out;

  logic [19:0]   addr_q, addr_d;
  logic [20:0]   tp_q, tp_d, tp_eff;
  logic          last_pix, wrap;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          clear_q, clear_d;
  logic          clr_pend_q, clr_pend_d;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        // Only ask for a burst when the whole burst is guaranteed to fit.
        if (ready && (count_q <= CW'(FIFO_DEPTH - SET_SIZE))) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_CAPTURE;
        wcnt_d  = '0;
      end
      S_CAPTURE: begin
        wcnt_d = wcnt_q + 5'd1;
        if (wcnt_q == 5'(SET_SIZE - 1)) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else if (render_reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign send_data = (state_q == S_REQ);

  // ---------------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------------
  assign push        = (state_q == S_CAPTURE);
  assign mem_we      = (count_q != '0);
  assign pop         = mem_we && mem_ready;
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign data_inside = (data >= HBI'(MAX_ITER));

  always_ff @(posedge CLK) begin
    if (push) begin
      pix_mem[wr_ptr_q] <= data[7:0];
    end
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (render_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_pix = pix_mem[rd_ptr_q];

`ifdef COLOR_MAP_EN
  logic inside_mem [FIFO_DEPTH];

  always_ff @(posedge CLK) begin
    if (push) begin
      inside_mem[wr_ptr_q] <= data_inside;
    end
  end

  // RGB332: R = it[2:0], G = it[5:3], B = it[7:6]; inside-set pixels are black.
  assign pix_out = inside_mem[rd_ptr_q] ? 8'h00
                                        : {head_pix[2:0], head_pix[5:3], head_pix[7:6]};
`else
  logic unused_data;
  assign unused_data = ^{data[HBI-1:8], data_inside};
  assign pix_out     = head_pix;
`endif

  // The FIFO RAM is not reset, so the data bus is forced to 0 while empty.
  assign mem_wdata = mem_we ? pix_out : 8'h00;

  // ---------------------------------------------------------------------------
  // Address counter, frame end and clear handshake
  // ---------------------------------------------------------------------------
  // total_pixels is live while the address is 0 and frozen for the rest of
  // the frame, so a change mid-frame only takes effect after the wrap.
  assign tp_eff   = (addr_q == '0) ? total_pixels : tp_q;
  assign last_pix = ({1'b0, addr_q} == (tp_eff - 21'd1));
  assign wrap     = pop && last_pix;

  always_comb begin
    addr_d       = addr_q;
    tp_d         = tp_q;
    frame_done_d = wrap;
    busy_d       = busy_q;
    clear_d      = 1'b0;
    clr_pend_d   = clr_pend_q;

    if (wrap) begin
      addr_d = '0;
    end else if (pop) begin
      addr_d = addr_q + 20'd1;
    end

    if (addr_q == '0) begin
      tp_d = total_pixels;
    end

    if (wrap) begin
      busy_d = 1'b0;
    end else if (push && (addr_q == '0)) begin
      busy_d = 1'b1;
    end

    // The acknowledge waits for frame_ready; it fires the cycle after the
    // pending flag and frame_ready are both seen.
    if (clr_pend_q && frame_ready) begin
      clear_d    = 1'b1;
      clr_pend_d = 1'b0;
    end
    if (wrap) begin
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      addr_q       <= '0;
      tp_q         <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      clear_q      <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else if (render_reset) begin
      addr_q       <= '0;
      tp_q         <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      clear_q      <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      tp_q         <= tp_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      clear_q      <= clear_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign mem_addr    = addr_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign clear_frame = clear_q;

  // Requests are gated on free space, so a push into a full FIFO is a bug.
  fifo_no_overflow: assert property (
    @(posedge CLK) disable iff (!SYS_RESET_N || render_reset)
      !(push && !pop && fifo_full)
  );

endmodule

// File: doc/iteration_frame_writer.md
Name: iteration_frame_writer

Overview:
Consumer end of the rendering engine's pixel output handshake. It requests bursts of SET_SIZE iteration counts and buffers them in an internal FIFO. Each count is converted to an 8-bit pixel and written at a linear frame-buffer address through a write port with back-pressure. At end of frame it pulses clear_frame back to the engine and restarts at address 0.

Parameters:
SET_SIZE, 1, words per burst; must match the engine's set_size (1..16)
HBI, 32, width of the iteration data word
MAX_ITER, 255, iteration value treated as "inside set"
FIFO_DEPTH, 32, pixel FIFO entries; power of two, >= 2*SET_SIZE

Ports:
CLK  in  1  system clock
SYS_RESET_N  in  1  asynchronous, active-low reset
render_reset  in  1  sync flush: engine restarted (button/update)
total_pixels  in  21  pixels per frame; sampled when the address counter is 0
ready  in  1  engine has a burst available
data  in  HBI  engine burst word
frame_ready  in  1  engine has emitted the whole frame
send_data  out  1  one-cycle burst request
clear_frame  out  1  one-cycle end-of-frame acknowledge
mem_we  out  1  frame-buffer write strobe
mem_addr  out  20  linear pixel address
mem_wdata  out  8  pixel value
mem_ready  in  1  frame buffer accepts the write this cycle
frame_done  out  1  one-cycle pulse when the last pixel is written
busy  out  1  high while a frame is being written

Behaviour:
- Reset (SYS_RESET_N=0, async): send_data, clear_frame, mem_we, frame_done, busy = 0; mem_addr = 0; mem_wdata = 0; FIFO empty; request FSM in IDLE.
- render_reset (sync, highest priority after reset): same values as reset, applied next edge; any in-flight burst is discarded.
- Request FSM:
  - IDLE -> REQ when ready=1 and FIFO free entries >= SET_SIZE.
  - REQ: send_data=1 for exactly one cycle T, then -> CAPTURE with word counter = 0.
  - CAPTURE: data is valid in cycles T+1 .. T+SET_SIZE, one word per cycle. Every word is pushed; there is no stall.
  - After word SET_SIZE-1 -> GAP for one cycle; the engine returns to its idle state here. GAP -> IDLE.
  - send_data is never raised in CAPTURE or GAP, even if ready is still high.
- FIFO stores data[7:0] plus an "inside" flag (data >= MAX_ITER). Push/pop in the same cycle is allowed. Overflow cannot occur by construction; an assertion checks it.
- Write side:
  - mem_we=1 whenever the FIFO is non-empty.
  - mem_addr and mem_wdata come from the FIFO head and are held stable until mem_we && mem_ready, which pops the entry and increments mem_addr.
  - Latency from data capture to the first mem_we is 1 cycle.
- Frame end:
  - When the accepted write has mem_addr == total_pixels_latched-1: mem_addr wraps to 0, frame_done pulses for 1 cycle, busy drops.
  - If frame_ready=1 at that point, clear_frame pulses 1 cycle later. Otherwise clear_frame pulses on the first cycle frame_ready is seen high.
- busy: set on the first push at address 0, cleared with frame_done.
- total_pixels changing mid-frame has no effect until the wrap.
- Address arithmetic is 20-bit unsigned; total_pixels above 2^20 is not supported.

Optional Feature:
COLOR_MAP_EN
- Defined: mem_wdata is RGB332. Inside-set pixels are 8'h00. Other pixels map as R = it[2:0], G = it[5:3], B = it[7:6], i.e. {it[2:0], it[5:3], it[7:6]}.
- Undefined: mem_wdata = data[7:0] unmodified (grayscale index). The inside flag is not stored.

Test Plan:
1. SET_SIZE=4, ready held high, mem_ready=1, data = 10, 11, 12, 13 -> send_data high for exactly 1 cycle; 4 writes at addr 0..3 with values 10..13. The next send_data comes no earlier than 6 cycles after the first.
2. mem_ready=0 for 100 cycles, FIFO_DEPTH=32, SET_SIZE=4 -> exactly 8 bursts requested and 32 entries held with no overflow. Releasing mem_ready drains them in 32 cycles at addr 0..31.
3. total_pixels=16, SET_SIZE=4, frame_ready rising after the 4th burst -> frame_done at the write to addr 15, addr wraps to 0, clear_frame 1 cycle later.
4. render_reset asserted in CAPTURE after 2 of 4 words -> FIFO empty, mem_addr=0, no mem_we next cycle. The next burst writes from addr 0.
5. SYS_RESET_N low mid-write -> all outputs 0 asynchronously, before the next clock edge.
6. COLOR_MAP_EN defined, data=255 -> wdata 8'h00. data=8'b10_101_011 -> wdata 8'b011_101_10.
